// File: rtl/bus_pkg.sv
// Shared bus-word layout, rw encoding and controller FSM states for bus_mem_ctrl.
package bus_pkg;

  localparam int BUS_W   = 25;
  localparam int RW_BIT  = 24;
  localparam int ADDR_HI = 23;
  localparam int ADDR_LO = 12;
  localparam int DATA_HI = 11;
  localparam int DATA_LO = 0;

  localparam logic BUS_RD = 1'b0;
  localparam logic BUS_WR = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/bus_mem_ram.sv
// Single-port synchronous word RAM with write enable and registered read port.
module bus_mem_ram #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4096,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic             re_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // NOTE: the array has no reset so it maps onto block RAM; contents are undefined until written.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/bus_mem_ctrl.sv
// Decodes packed bus words into local RAM reads/writes, one response per request.
// Define BUS_MEM_CTRL_PARITY_EN to store an even-parity bit per word and flag mismatches on read.
module bus_mem_ctrl
  import bus_pkg::*;
#(
  parameter int ADDR_W    = ADDR_HI - ADDR_LO + 1,
  parameter int DATA_W    = DATA_HI - DATA_LO + 1,
  parameter int MEM_DEPTH = 4096
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDR_W+DATA_W:0]   bus_in,
  input  logic                     bus_valid,
  output logic                     bus_ready,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [DATA_W-1:0]        resp_data,
  output logic                     resp_wr,
  output logic                     resp_err
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
`ifdef BUS_MEM_CTRL_PARITY_EN
  localparam int RAM_W = DATA_W + 1;
`else
  localparam int RAM_W = DATA_W;
`endif

  state_e             state_q, state_d;
  logic               bus_ready_q, bus_ready_d;
  logic [DATA_W-1:0]  resp_data_q, resp_data_d;
  logic               resp_wr_q, resp_wr_d;
  logic               resp_err_q, resp_err_d;

  logic               req_rw;
  logic [ADDR_W-1:0]  req_addr;
  logic [DATA_W-1:0]  req_data;
  logic               req_oor;
  logic               accept;

  logic               ram_we, ram_re;
  logic [RAM_W-1:0]   ram_wdata, ram_rdata;
  logic               parity_err;

  assign req_rw   = bus_in[ADDR_W+DATA_W];
  assign req_addr = bus_in[DATA_W +: ADDR_W];
  assign req_data = bus_in[DATA_W-1:0];
  assign req_oor  = ({1'b0, req_addr} >= (ADDR_W+1)'(MEM_DEPTH));
  assign accept   = bus_valid && bus_ready_q;

`ifdef BUS_MEM_CTRL_PARITY_EN
  assign ram_wdata  = {^req_data, req_data};
  assign parity_err = ^ram_rdata;
`else
  assign ram_wdata  = req_data;
  assign parity_err = 1'b0;
`endif

  // The RAM sees the live bus address; the read is captured at the accept edge.
  bus_mem_ram #(
    .WIDTH (RAM_W),
    .DEPTH (MEM_DEPTH),
    .AW    (IDX_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .re_i    (ram_re),
    .addr_i  (req_addr[IDX_W-1:0]),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    resp_data_d = resp_data_q;
    resp_wr_d   = resp_wr_q;
    resp_err_d  = resp_err_q;
    ram_we      = 1'b0;
    ram_re      = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          resp_wr_d   = req_rw;
          resp_data_d = '0;
          state_d     = RESP;
          if (req_oor) begin
            resp_err_d = 1'b1;
          end else begin
            resp_err_d = 1'b0;
            if (req_rw == BUS_WR) begin
              ram_we = 1'b1;
            end else begin
              ram_re  = 1'b1;
              state_d = READ;
            end
          end
        end
      end
      READ: begin
        resp_data_d = ram_rdata[DATA_W-1:0];
        resp_wr_d   = 1'b0;
        resp_err_d  = parity_err;
        state_d     = RESP;
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered ready keeps it low through the reset cycle and free of any resp_ready path.
  assign bus_ready_d = (state_d == IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bus_ready_q <= 1'b0;
      resp_data_q <= '0;
      resp_wr_q   <= 1'b0;
      resp_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bus_ready_q <= bus_ready_d;
      resp_data_q <= resp_data_d;
      resp_wr_q   <= resp_wr_d;
      resp_err_q  <= resp_err_d;
    end
  end

  assign bus_ready  = bus_ready_q;
  assign resp_valid = (state_q == RESP);
  assign resp_data  = resp_data_q;
  assign resp_wr    = resp_wr_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_bus_mem_ctrl.sv
// Directed bench for bus_mem_ctrl with a 256-word memory; expected values are hand-computed.
module tb_bus_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [24:0] bus_in;
  logic        bus_valid;
  logic        bus_ready;
  logic        resp_valid;
  logic        resp_ready;
  logic [11:0] resp_data;
  logic        resp_wr;
  logic        resp_err;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bus_mem_ctrl #(
    .ADDR_W    (12),
    .DATA_W    (12),
    .MEM_DEPTH (256)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus_in     (bus_in),
    .bus_valid  (bus_valid),
    .bus_ready  (bus_ready),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_wr    (resp_wr),
    .resp_err   (resp_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one request while bus_ready is high; returns just after the accepting edge.
  task automatic send(input logic rw, input logic [11:0] addr, input logic [11:0] data);
    bus_in    = {rw, addr, data};
    bus_valid = 1'b1;
    tick();
    bus_valid = 1'b0;
  endtask

  task automatic check_resp(input string tag, input logic [11:0] d, input logic wr, input logic err);
    check({tag, "_valid"}, 32'(resp_valid), 32'd1);
    check({tag, "_data"},  32'(resp_data),  32'(d));
    check({tag, "_wr"},    32'(resp_wr),    32'(wr));
    check({tag, "_err"},   32'(resp_err),   32'(err));
  endtask

  task automatic finish_resp(input string tag);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check({tag, "_done_valid"}, 32'(resp_valid), 32'd0);
    check({tag, "_done_ready"}, 32'(bus_ready),  32'd1);
  endtask

  initial begin
    rst        = 1'b1;
    bus_in     = '0;
    bus_valid  = 1'b0;
    resp_ready = 1'b0;

    tick();
    check("rst_ready", 32'(bus_ready),  32'd0);
    check("rst_valid", 32'(resp_valid), 32'd0);
    check("rst_data",  32'(resp_data),  32'd0);
    check("rst_wr",    32'(resp_wr),    32'd0);
    check("rst_err",   32'(resp_err),   32'd0);
    rst = 1'b0;
    tick();
    check("post_rst_ready", 32'(bus_ready), 32'd1);

    // Write 0x005 <= 0xABC: response one cycle after the handshake.
    send(1'b1, 12'h005, 12'hABC);
    check_resp("wr5", 12'h000, 1'b1, 1'b0);
    check("wr5_busy", 32'(bus_ready), 32'd0);
    finish_resp("wr5");

    // Read 0x005: nothing after one cycle, data after two.
    send(1'b0, 12'h005, 12'h000);
    check("rd5_lat1", 32'(resp_valid), 32'd0);
    check("rd5_busy", 32'(bus_ready),  32'd0);
    tick();
    check_resp("rd5", 12'hABC, 1'b0, 1'b0);
    finish_resp("rd5");

    // Seed 0x000 and the last in-range word 0x0FF.
    send(1'b1, 12'h000, 12'h123);
    finish_resp("wr0");
    send(1'b1, 12'h0FF, 12'h7E5);
    finish_resp("wrff");

    // Out-of-range read and write at the first address past the memory.
    send(1'b0, 12'h100, 12'h000);
    check_resp("rd100", 12'h000, 1'b0, 1'b1);
    finish_resp("rd100");
    send(1'b1, 12'h100, 12'hFFF);
    check_resp("wr100", 12'h000, 1'b1, 1'b1);
    finish_resp("wr100");

    // Memory untouched by the out-of-range write (index bits alias 0x000).
    send(1'b0, 12'h000, 12'h000);
    tick();
    check_resp("rd0", 12'h123, 1'b0, 1'b0);
    finish_resp("rd0");
    send(1'b0, 12'h0FF, 12'h000);
    tick();
    check_resp("rdff", 12'h7E5, 1'b0, 1'b0);
    finish_resp("rdff");

    // Backpressure: response held for 5 cycles while a new read waits on the bus.
    send(1'b1, 12'h010, 12'h555);
    bus_in    = {1'b0, 12'h010, 12'h000};
    bus_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check_resp($sformatf("stall%0d", i), 12'h000, 1'b1, 1'b0);
      check($sformatf("stall%0d_ready", i), 32'(bus_ready), 32'd0);
      tick();
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check("stall_rel_valid", 32'(resp_valid), 32'd0);
    check("stall_rel_ready", 32'(bus_ready),  32'd1);
    tick();
    bus_valid = 1'b0;
    check("stall_acc_valid", 32'(resp_valid), 32'd0);
    check("stall_acc_ready", 32'(bus_ready),  32'd0);
    tick();
    check_resp("stall_rd", 12'h555, 1'b0, 1'b0);
    finish_resp("stall_rd");

    // Reset while in READ drops the pending response.
    send(1'b0, 12'h005, 12'h000);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_valid", 32'(resp_valid), 32'd0);
    check("mid_rst_ready", 32'(bus_ready),  32'd0);
    tick();
    check("mid_rst_ready2", 32'(bus_ready),  32'd1);
    check("mid_rst_valid2", 32'(resp_valid), 32'd0);
    tick();
    check("mid_rst_stale", 32'(resp_valid), 32'd0);
    check("mid_rst_data",  32'(resp_data),  32'd0);

    // Committed write survives the reset.
    send(1'b0, 12'h005, 12'h000);
    tick();
    check_resp("rd5_after_rst", 12'hABC, 1'b0, 1'b0);
    finish_resp("rd5_after_rst");

`ifdef BUS_MEM_CTRL_PARITY_EN
    dut.u_ram.mem_q[5][0] = ~dut.u_ram.mem_q[5][0];
    send(1'b0, 12'h005, 12'h000);
    tick();
    check_resp("par5", 12'hABD, 1'b0, 1'b1);
    finish_resp("par5");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bus_mem_ctrl.md
Name: bus_mem_ctrl

Overview:
- Downstream consumer of the 25-bit packed bus word {rw, addr[11:0], data[11:0]}.
- Decodes each accepted word into a read or write on a local synchronous word memory; returns one response per request over a valid/ready handshake.
- Sits between the bus packing stage and the processor's data/instruction store. One outstanding request at a time.

Parameters:
- ADDR_W, 12, address field width (bus bits [23:12]).
- DATA_W, 12, data field width (bus bits [11:0]).
- MEM_DEPTH, 4096, implemented words. Must be <= 2**ADDR_W. Addresses >= MEM_DEPTH are out of range.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- bus_in  input  1+ADDR_W+DATA_W (25)  packed word: bit 24 = rw (1 write, 0 read), [23:12] = addr, [11:0] = data.
- bus_valid  input  1  bus_in holds a request.
- bus_ready  output  1  controller can accept; transfer when bus_valid && bus_ready.
- resp_valid  output  1  response held on resp_* outputs.
- resp_ready  input  1  consumer takes response; transfer when resp_valid && resp_ready.
- resp_data  output  DATA_W  read data; 0 for writes and errors.
- resp_wr  output  1  response is for a write.
- resp_err  output  1  address out of range (or parity error, see Optional Feature).

Behaviour:
- Reset outputs: bus_ready=0 during the reset cycle and 1 in the first cycle after it; resp_valid=0, resp_data=0, resp_wr=0, resp_err=0; state=IDLE.
- Memory contents are not reset.
- FSM states: IDLE, READ, RESP.
- IDLE:
  - bus_ready=1.
  - On transfer, latch rw/addr.
  - In-range write: RAM written on that edge; go to RESP with resp_wr=1, resp_data=0, resp_err=0.
  - In-range read: issue RAM read; go to READ.
  - Out-of-range (either rw): RAM untouched; go to RESP with resp_err=1, resp_data=0, resp_wr=rw.
- READ: bus_ready=0. The RAM output is valid this cycle. Register it into resp_data, set resp_wr=0, then go to RESP.
- RESP:
  - bus_ready=0, resp_valid=1.
  - resp_* outputs stay stable until the handshake completes.
  - On resp_ready, resp_valid falls on the next edge and the FSM returns to IDLE.
- Latency, request handshake to resp_valid: write or error = 1 cycle; read = 2 cycles.
- Back-to-back throughput: one request per 2 cycles (write) or 3 cycles (read), assuming resp_ready is held high.
- bus_ready does not depend combinationally on resp_ready; there is no bypass.
- bus_valid while bus_ready=0 is ignored; the upstream stage must hold it.
- Read after write to the same address returns the new data (the write completes before the next accept).
- rst asserted mid-operation: FSM goes to IDLE and any pending response is dropped. A write already committed on an earlier edge stays in memory.

Optional Feature:
- Macro: BUS_MEM_CTRL_PARITY_EN.
- Defined:
  - RAM is DATA_W+1 bits wide; writes store even parity (XOR) of the data.
  - A read whose stored parity mismatches sets resp_err=1 and still returns the data.
- Undefined:
  - RAM is DATA_W wide; resp_err flags out-of-range only.

Decomposition:
- Package bus_pkg holds:
  - BUS_W=25, RW_BIT=24, ADDR_HI=23, ADDR_LO=12, DATA_HI=11, DATA_LO=0.
  - The rw encoding constants BUS_RD=0, BUS_WR=1.
  - The FSM state enum.
- Sub-module bus_mem_ram: single-port synchronous RAM with registered read and write-enable; parameterised on width and depth.

Test Plan:
- Reset, then write addr=0x005, data=0xABC -> 1 cycle later resp_valid=1, resp_wr=1, resp_err=0, resp_data=0.
- Read addr=0x005 -> resp_valid 2 cycles after handshake; resp_data=0xABC, resp_wr=0, resp_err=0.
- MEM_DEPTH=256; read addr=0x100 -> resp_err=1, resp_data=0; memory unchanged (a subsequent read of 0x000 returns its prior value).
- Hold resp_ready=0 for 5 cycles -> resp_* stable, bus_ready=0 throughout; an asserted bus_valid is not accepted until the cycle after the resp handshake.
- Assert rst in the READ state -> next cycle resp_valid=0, bus_ready=0; the cycle after that bus_ready=1 and no stale response appears.
- With BUS_MEM_CTRL_PARITY_EN defined, force-flip a stored bit of addr 0x005 -> read returns the corrupted data with resp_err=1.
